// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths and buffer sizes used by receiver, transmitter and FIFOs
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_RX_FIFO_DEPTH = 8;
endpackage

// File: rtl/bit_sync2.sv
// bit_sync2: two-flop synchronizer for a single-bit level, async reset to 0
module bit_sync2 (
  input  logic budclk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge budclk or posedge reset)
    if (reset) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive FIFO with edge-triggered push, synchronized CPU pop and sticky overrun
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     budclk,
  input  logic                     reset,
  input  logic                     rx_done,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rd_req,
  input  logic                     ovr_clr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rx_done_q, rd_sync, rd_q, push, pop, do_push, do_pop, ovr_event;
  bit_sync2 u_rd_sync (.budclk(budclk), .reset(reset), .d(rd_req), .q(rd_sync));
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign irq = ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // a pop frees the slot a full-FIFO push needs, so overrun only fires without one
  always_comb begin
    push = rx_done & ~rx_done_q;
    pop = rd_sync & ~rd_q;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    ovr_event = push & full & ~pop;
  end
  always_ff @(posedge budclk or posedge reset)
    if (reset) begin
      rx_done_q <= 1'b1;
      rd_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      rd_q <= rd_sync;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overrun <= ovr_event | (overrun & ~ovr_clr);
    end
  always_ff @(posedge budclk)
    if (do_push) mem[wr_ptr] <= rx_data;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter WIDTH, default 8, bits per entry.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-004 SHALL have port budclk, input, 1; all state is clocked on its rising edge.
REQ-005 SHALL have port rx_done, input, 1, byte-complete level from the UART receiver (budclk domain).
REQ-006 SHALL have port rx_data, input, WIDTH, received byte, valid while rx_done is high.
REQ-007 SHALL have port rd_req, input, 1, CPU pop request from the sysclk domain (asynchronous to budclk).
REQ-008 SHALL have port ovr_clr, input, 1, synchronous clear of the overrun flag.
REQ-009 SHALL have port rd_data, output, WIDTH, oldest entry (show-ahead).
REQ-010 SHALL have port empty, output, 1, FIFO holds no entries.
REQ-011 SHALL have port full, output, 1, FIFO holds DEPTH entries.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-013 SHALL have port overrun, output, 1, sticky byte-lost flag.
REQ-014 SHALL have port irq, output, 1, receive-data-available interrupt.

Function
REQ-015 SHALL register rx_done into rx_done_q each cycle; push = rx_done & ~rx_done_q, so exactly one push per rx_done rising edge.
REQ-016 SHALL, on push with count < DEPTH, write rx_data at wr_ptr at that same edge; wr_ptr +1 modulo DEPTH.
REQ-017 SHALL, on push with count == DEPTH and no pop that cycle, discard rx_data and set overrun; contents unchanged.
REQ-018 SHALL pass rd_req through a 2-flop synchronizer then a rising-edge detector; pop asserts on the 3rd budclk edge after rd_req is first sampled high; one pop per rd_req rising edge, however long it is held.
REQ-019 SHALL, on pop with count > 0, advance rd_ptr +1 modulo DEPTH; pop on empty is ignored, no flag.
REQ-020 SHALL, on simultaneous push and pop with count == DEPTH, perform both; count stays DEPTH; overrun not set.
REQ-021 SHALL, on simultaneous push and pop with count == 0, perform the push only; count becomes 1.
REQ-022 SHALL, on simultaneous push and pop otherwise, perform both; count unchanged.
REQ-023 SHALL drive rd_data = mem[rd_ptr] when count > 0, 0x00 when empty; no added latency after a push.
REQ-024 SHALL drive empty = (count == 0), full = (count == DEPTH), irq = ~empty, all from registered count.
REQ-025 SHALL clear overrun on ovr_clr; a simultaneous new overrun event wins (flag stays set).

Reset
REQ-026 SHALL on reset clear wr_ptr, rd_ptr, count, overrun, and both synchronizer flops plus the rd edge-detect flop to 0.
REQ-027 SHALL on reset set rx_done_q to 1, so a level rx_done present at reset release does not cause a push.
REQ-028 SHALL produce these outputs during and after reset until the first event: rd_data 0x00, empty 1, full 0, count 0, overrun 0, irq 0.
REQ-029 SHALL NOT reset memory contents.
REQ-030 SHALL, when reset is asserted mid-operation, drop all queued bytes and lose any pending synchronized pop.

Structure
REQ-031 SHALL take UART_DATA_W (8) and UART_RX_FIFO_DEPTH (8) from shared package uart_pkg, also used by the receiver and transmitter.
REQ-032 SHALL instantiate one sub-module, bit_sync2 (2-flop synchronizer, async reset to 0), for rd_req.
REQ-033 SHALL implement storage as a flop array without a reset.

Verification
REQ-034 SHALL cover: reset, then rx_done pulses with 0x41 then 0x42 -> count 2, rd_data 0x41; one rd_req pulse -> 3 edges later rd_data 0x42, count 1.
REQ-035 SHALL cover: 9 pushes (0x00..0x08), DEPTH 8 -> full 1, count 8, overrun 1, rd_data 0x00; 8 pops yield 0x00..0x07, then empty 1.
REQ-036 SHALL cover: full FIFO with push 0x55 and pop on the same edge -> count 8, overrun 0, new tail 0x55.
REQ-037 SHALL cover: empty FIFO with push 0x33 and pop on the same edge -> count 1, rd_data 0x33; and rd_req held high for 20 cycles -> exactly one pop.
REQ-038 SHALL cover: rx_done held high across reset release -> no push, count 0; ovr_clr together with an overflow push -> overrun stays 1, next ovr_clr alone -> 0.
REQ-039 SHALL cover: 20 push/pop pairs, pointer wrap past DEPTH -> data order preserved, count returns to 0.
